// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types used by the unified memory arbiter
package pipeline_pkg;

   // Arbiter states: idle, serving the data port, serving the fetch port
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_D = 2'd1,
      BUSY_I = 2'd2
   } mem_arb_state_t;

   // Cycles to wait for a memory ack before abandoning the access
   localparam int MEM_TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter in front of one single-ported unified memory
module mem_arbiter
   import pipeline_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = MEM_TIMEOUT_DEFAULT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  stall_f_i,
   input  logic                  imem_req_i,
   input  logic [ADDR_WIDTH-1:0] imem_addr_i,
   output logic [DATA_WIDTH-1:0] imem_rdata_o,
   output logic                  imem_stall_o,
   input  logic                  dmem_req_i,
   input  logic                  dmem_we_i,
   input  logic [ADDR_WIDTH-1:0] dmem_addr_i,
   input  logic [DATA_WIDTH-1:0] dmem_wdata_i,
   output logic [DATA_WIDTH-1:0] dmem_rdata_o,
   output logic                  dmem_stall_o,
   output logic                  mem_req_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i,
   input  logic                  mem_ack_i,
   output logic                  bus_err_o
);

   // The counter only ever reaches TIMEOUT-1 before the access is abandoned
   localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   mem_arb_state_t   state;
   logic [CNT_W-1:0] cnt;
   logic             i_done;
   logic             d_done;
   logic             freeze;
   logic             access_end;

   // A port stalls while it asks for an access whose result is not yet held
   assign imem_stall_o = imem_req_i & ~i_done;
   assign dmem_stall_o = dmem_req_i & ~d_done;
   assign freeze       = imem_stall_o | dmem_stall_o;
   assign access_end   = mem_ack_i | (cnt == CNT_LAST);

   // Arbitration, memory handshake, result capture and done-flag bookkeeping
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         cnt          <= '0;
         mem_req_o    <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= '0;
         mem_wdata_o  <= '0;
         i_done       <= 1'b0;
         d_done       <= 1'b0;
         imem_rdata_o <= '0;
         dmem_rdata_o <= '0;
         bus_err_o    <= 1'b0;
      end else begin
         // Results are released once the pipeline advances; a fetched
         // instruction is additionally kept while the hazard unit stalls F.
         // A completion later in this block overrides these clears.
         if (!freeze) begin
            d_done <= 1'b0;
         end
         if (!freeze && !stall_f_i) begin
            i_done <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (dmem_req_i && !d_done) begin
                  mem_req_o   <= 1'b1;
                  mem_we_o    <= dmem_we_i;
                  mem_addr_o  <= dmem_addr_i;
                  mem_wdata_o <= dmem_wdata_i;
                  state       <= BUSY_D;
               end else if (imem_req_i && !i_done) begin
                  mem_req_o  <= 1'b1;
                  mem_we_o   <= 1'b0;
                  mem_addr_o <= imem_addr_i;
                  state      <= BUSY_I;
               end
            end

            BUSY_D, BUSY_I: begin
               if (access_end) begin
                  mem_req_o <= 1'b0;
                  cnt       <= '0;
                  state     <= IDLE;
                  if (!mem_ack_i) begin
                     bus_err_o <= 1'b1;
                  end
                  if (state == BUSY_D) begin
                     d_done <= 1'b1;
                     if (!mem_ack_i) begin
                        dmem_rdata_o <= '0;
                     end else if (!mem_we_o) begin
                        dmem_rdata_o <= mem_rdata_i;
                     end
                  end else begin
                     i_done       <= 1'b1;
                     imem_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
